// File: rtl/seg7_scan_ctrl_if.sv
// Display bus between the register block and the scan controller: live
// digit data/attributes in, registered anode/segment drives out.
interface seg7_scan_ctrl_if #(
  parameter int DIGITS      = 8,
  parameter int BRIGHT_BITS = 4
);
  logic [4*DIGITS-1:0]    data;
  logic [DIGITS-1:0]      dp_in;
  logic [DIGITS-1:0]      digit_en;
  logic                   lz_blank;
  logic [BRIGHT_BITS-1:0] brightness;
  logic [DIGITS-1:0]      AN;
  logic [7:0]             SEG;
  logic                   frame_done;

  modport master (
    output data, dp_in, digit_en, lz_blank, brightness,
    input  AN, SEG, frame_done
  );

  modport slave (
    input  data, dp_in, digit_en, lz_blank, brightness,
    output AN, SEG, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller. Captures inputs only at
// frame boundaries, rotates one anode per slot with a dead cycle, applies
// leading-zero blanking, per-digit enable/dp and PWM brightness.

// Per-digit lane: hex-to-segment decode (active-high, {g..a}) and zero flag.
module seg7_lane (
  input  logic [3:0] nib,
  output logic [6:0] seg,
  output logic       zero
);
  assign zero = (nib == 4'h0);

  // Hex glyph table
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

module seg7_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int CLK_DIV     = 2500,
  parameter int BRIGHT_BITS = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_ctrl_if.slave bus
);
  localparam int             PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int             SW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic           INV    = (ACTIVE_LOW != 0);
  localparam logic [PW-1:0]  P_LAST = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0]  S_LAST = SW'(DIGITS - 1);

  logic [PW-1:0]          p;
  logic [SW-1:0]          sel;
  logic [BRIGHT_BITS-1:0] w;

  logic [DIGITS-1:0][3:0] sh_data;
  logic [DIGITS-1:0]      sh_dp;
  logic [DIGITS-1:0]      sh_en;
  logic                   sh_lz;
  logic [BRIGHT_BITS-1:0] sh_br;

  logic slot_end, frame_end;
  assign slot_end  = (p == P_LAST);
  assign frame_end = slot_end && (sel == S_LAST);

  // Prescaler, slot index and free-running PWM counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      sel <= '0;
      w   <= '0;
    end else begin
      w <= w + 1'b1;
      if (slot_end) begin
        p   <= '0;
        sel <= (sel == S_LAST) ? '0 : sel + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
    end
  end

  // Shadow capture only at frame boundaries so a frame never mixes old/new data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
      sh_lz   <= 1'b0;
      sh_br   <= '0;
    end else if (frame_end) begin
      sh_data <= bus.data;
      sh_dp   <= bus.dp_in;
      sh_en   <= bus.digit_en;
      sh_lz   <= bus.lz_blank;
      sh_br   <= bus.brightness;
    end
  end

  logic [DIGITS-1:0][6:0] lane_seg;
  logic [DIGITS-1:0]      lane_zero;

  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    seg7_lane u_lane (
      .nib  (sh_data[i]),
      .seg  (lane_seg[i]),
      .zero (lane_zero[i])
    );
  end

  // Leading-zero mask: a digit is suppressed when it and all higher digits are 0
  logic [DIGITS-1:0] sup;
  logic              hz;
  always_comb begin
    sup = '0;
    hz  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hz     = hz & lane_zero[i];
      sup[i] = sh_lz && hz && (i > 0);
    end
  end

  // Select the attributes of the digit in the current slot
  logic [6:0]        cur_seg;
  logic              cur_dp, cur_en, cur_sup;
  logic [DIGITS-1:0] an_onehot;
  always_comb begin
    cur_seg   = '0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_sup   = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SW'(i)) begin
        cur_seg      = lane_seg[i];
        cur_dp       = sh_dp[i];
        cur_en       = sh_en[i];
        cur_sup      = sup[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  logic pwm_on, lit, show;
  assign pwm_on = (&sh_br) || (w < sh_br);
  // p==0 is the anti-ghost dead cycle at the start of every slot
  assign lit    = (p != '0) && cur_en && pwm_on && !cur_sup;
  // Segment pattern follows the digit even through dead/PWM-off cycles
  assign show   = cur_en && !cur_sup;

  // Registered pin drives with polarity applied last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.AN         <= {DIGITS{INV}};
      bus.SEG        <= {8{INV}};
      bus.frame_done <= 1'b0;
    end else begin
      bus.AN         <= (lit ? an_onehot : '0) ^ {DIGITS{INV}};
      bus.SEG        <= (show ? {cur_dp, cur_seg} : 8'h00) ^ {8{INV}};
      bus.frame_done <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (fast scan active-low, slow scan
// active-high) share the same inputs and are compared every cycle against a
// time-based reference model.
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_on = 1'b0;
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.DIGITS(4), .BRIGHT_BITS(4)) ifa ();
  seg7_scan_ctrl_if #(.DIGITS(4), .BRIGHT_BITS(4)) ifb ();

  seg7_scan_ctrl #(.DIGITS(4), .CLK_DIV(4), .BRIGHT_BITS(4), .ACTIVE_LOW(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  seg7_scan_ctrl #(.DIGITS(4), .CLK_DIV(32), .BRIGHT_BITS(4), .ACTIVE_LOW(0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [3:0]  br;
  } shadow_t;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Output the display should show after the edge that ends cycle t
  function automatic logic [11:0] mdl(input int t, input int cdiv, input bit al, input shadow_t s);
    int p, sel, w;
    bit pwm, sup, lit;
    logic [3:0] an;
    logic [7:0] seg;
    p   = t % cdiv;
    sel = (t / cdiv) % 4;
    w   = t % 16;
    pwm = (s.br == 4'hF) || (w < int'(s.br));
    sup = 1'b0;
    if (s.lz && sel > 0) begin
      sup = 1'b1;
      for (int j = sel; j < 4; j++) if (s.d[4*j +: 4] != 4'h0) sup = 1'b0;
    end
    lit = (p != 0) && s.en[sel] && pwm && !sup;
    an  = lit ? 4'(1 << sel) : 4'h0;
    seg = (s.en[sel] && !sup) ? {s.dp[sel], hex7(s.d[4*sel +: 4])} : 8'h00;
    if (al) begin
      an  = ~an;
      seg = ~seg;
    end
    return {an, seg};
  endfunction

  shadow_t     cur_in, sh_a, sh_b;
  int          t;
  logic [12:0] exp_a, exp_b;

  assign cur_in = '{d: ifa.data, dp: ifa.dp_in, en: ifa.digit_en, lz: ifa.lz_blank, br: ifa.brightness};

  // Reference model: state is derived from elapsed cycles since reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t     <= 0;
      sh_a  <= '0;
      sh_b  <= '0;
      exp_a <= {1'b0, 4'hF, 8'hFF};
      exp_b <= 13'h0;
    end else begin
      exp_a <= {(t % 16) == 15, mdl(t, 4, 1'b1, sh_a)};
      exp_b <= {(t % 128) == 127, mdl(t, 32, 1'b0, sh_b)};
      if ((t % 16) == 15)   sh_a <= cur_in;
      if ((t % 128) == 127) sh_b <= cur_in;
      t <= t + 1;
    end
  end

  // Cycle-by-cycle comparison on the inactive edge
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("a_an",  16'(ifa.AN),         16'(exp_a[11:8]));
      chk("a_seg", 16'(ifa.SEG),        16'(exp_a[7:0]));
      chk("a_fd",  16'(ifa.frame_done), 16'(exp_a[12]));
      chk("b_an",  16'(ifb.AN),         16'(exp_b[11:8]));
      chk("b_seg", 16'(ifb.SEG),        16'(exp_b[7:0]));
      chk("b_fd",  16'(ifb.frame_done), 16'(exp_b[12]));
    end
  end

  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                        input logic lz, input logic [3:0] br);
    ifa.data = d;  ifa.dp_in = dp;  ifa.digit_en = en;  ifa.lz_blank = lz;  ifa.brightness = br;
    ifb.data = d;  ifb.dp_in = dp;  ifb.digit_en = en;  ifb.lz_blank = lz;  ifb.brightness = br;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [15:0] d, mask;
    set_in(16'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    run(3);
    rst = 1'b0;
    chk_on = 1'b1;

    // first frame_done lands 16 cycles after release
    n = 0;
    while (!ifa.frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("first_fd", 16'(n), 16'd16);

    // directed scenarios
    set_in(16'h12A0, 4'h0, 4'hF, 1'b0, 4'hF); run(300);
    set_in(16'h0050, 4'h0, 4'hF, 1'b1, 4'hF); run(300);
    set_in(16'h0000, 4'h0, 4'hF, 1'b1, 4'hF); run(300);
    set_in(16'h1234, 4'h0, 4'hF, 1'b0, 4'h0); run(300);
    set_in(16'h1234, 4'h0, 4'hF, 1'b0, 4'h8); run(300);
    set_in(16'h1111, 4'h0, 4'hF, 1'b0, 4'hF); run(133);
    set_in(16'h2222, 4'h0, 4'hF, 1'b0, 4'hF); run(300);
    set_in(16'h5678, 4'h2, 4'hB, 1'b0, 4'hF); run(300);

    // random patterns held for random, mostly mid-frame, intervals
    for (int k = 0; k < 80; k++) begin
      mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
      d    = 16'($urandom) & mask;
      case ($urandom_range(0, 2))
        0:       set_in(d, 4'($urandom), 4'($urandom), 1'($urandom), 4'h0);
        1:       set_in(d, 4'($urandom), 4'($urandom), 1'($urandom), 4'hF);
        default: set_in(d, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      endcase
      run($urandom_range(1, 200));
    end

    // asynchronous reset between edges takes effect without a clock
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_a_an",  16'(ifa.AN),         16'h000F);
    chk("rst_a_seg", 16'(ifa.SEG),        16'h00FF);
    chk("rst_a_fd",  16'(ifa.frame_done), 16'h0000);
    chk("rst_b_an",  16'(ifb.AN),         16'h0000);
    chk("rst_b_seg", 16'(ifb.SEG),        16'h0000);
    @(negedge clk);
    set_in(16'h9ABC, 4'hF, 4'hF, 1'b0, 4'hF);
    rst = 1'b0;
    run(200);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller. It replaces the ad-hoc anode-rotation logic in board tops and drives the digit anodes (AN) and segment lines (SEG) of an N-digit display from packed hex nibbles. It adds an internal scan prescaler, frame-synchronous (tear-free) input capture, per-digit enables and decimal points, leading-zero blanking, PWM brightness and an anti-ghosting dead cycle. It sits at board level between CPU-visible display registers and the board pins.

Parameters:
DIGITS, 8, number of digits; legal range 1..16.
CLK_DIV, 2500, clk cycles per digit slot; must be at least 2.
BRIGHT_BITS, 4, width of the brightness control and of the PWM counter.
ACTIVE_LOW, 1, when 1, AN and SEG are active-low; when 0, both are active-high.

Ports:
clk  in  1  single clock; every register is clocked by it.
rst  in  1  asynchronous, active-high reset.
data  in  4*DIGITS  hex nibble per digit; digit i is data[4i+3:4i], and digit 0 is the rightmost.
dp_in  in  DIGITS  decimal point request per digit.
digit_en  in  DIGITS  per-digit enable; 0 forces that anode inactive.
lz_blank  in  1  enables leading-zero suppression.
brightness  in  BRIGHT_BITS  0 = off; all-ones = full on.
AN  out  DIGITS  anode drives, registered.
SEG  out  8  segment drives, registered; SEG[7]=dp, SEG[6:0]={g,f,e,d,c,b,a}.
frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async, immediate):
  - AN and SEG go to the inactive level (all 1s if ACTIVE_LOW, otherwise all 0s).
  - frame_done=0.
  - Prescaler p=0, slot index sel=0, PWM counter w=0.
  - Shadow registers (data, dp, enable, lz, brightness) cleared to 0.
- Prescaler:
  - p counts 0..CLK_DIV-1 and wraps.
  - When p==CLK_DIV-1, sel advances by one; it wraps from DIGITS-1 to 0.
- Frame boundary (p==CLK_DIV-1 and sel==DIGITS-1), in the same edge:
  - Shadow registers load from the live inputs.
  - frame_done goes to 1 for exactly one cycle.
  - Inputs never affect the outputs except through the shadow registers, so mid-frame input changes are invisible until the next boundary.
  - After reset, shadow enables are 0, so the whole first frame is blank.
- PWM:
  - w is free-running modulo 2^BRIGHT_BITS.
  - pwm_on = (shadow brightness == all-ones) OR (w < shadow brightness).
- Leading-zero suppression: digit i (i>0) is blanked when all of the following hold:
  - shadow lz is set;
  - nibble i is 0;
  - every nibble above i is 0.
  - Digit 0 is never suppressed.
- Lit condition for the digit in slot sel: p != 0 (one dead cycle per slot) AND shadow digit_en[sel] AND pwm_on AND the digit is not suppressed.
- Outputs (registered, one cycle after the state that produces them):
  - AN: only bit sel is active, and only when the lit condition holds; otherwise every bit is inactive.
  - SEG: hex decode of nibble sel in active-high form, then inverted if ACTIVE_LOW.
  - Hex decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - SEG[7] = shadow dp[sel].
  - A suppressed or disabled digit outputs SEG inactive.
- Simultaneous events: reset dominates everything. Boundary loading and frame_done happen in the same edge that wraps sel to 0.

Test Plan:
1. Reset: run with DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1 and mid-slot activity, then assert rst between clock edges -> AN=4'hF and SEG=8'hFF immediately, with no clock edge needed; after release, frame_done first pulses 16 cycles later, and AN stays 4'hF throughout that first frame.
2. Basic scan: data=16'h12A0, digit_en=4'hF, brightness=4'hF, dp_in=0. In the second frame:
   - slot 0: AN=4'b1110 and SEG=8'hC0 on 3 of 4 cycles, with AN=4'hF on the dead cycle;
   - slot 1: SEG=8'h88; slot 2: SEG=8'hA4; slot 3: SEG=8'hF9;
   - frame_done pulses every 16 cycles.
3. Leading zeros: data=16'h0050, lz_blank=1 -> digits 3 and 2 are never active; digit 1 shows SEG=8'h92; digit 0 shows 8'hC0. Then data=16'h0000 -> only digit 0 is lit, showing 8'hC0.
4. Brightness, with CLK_DIV=32: brightness=0 -> AN is constantly 4'hF. brightness=8 -> in each slot, the anode is active exactly on cycles where w<8 and p!=0.
5. Tear-free update: change data from 16'h1111 to 16'h2222 while sel=1 -> slots 1..3 still show SEG=8'hF9; 8'hA4 appears first in slot 0 after the next frame_done.
6. Enables and dp: digit_en=4'b1011, dp_in=4'b0010 -> digit 2 is never active; digit 1 shows SEG[7]=0 (lit); the other digits show SEG[7]=1.
